minesweeper_top: RTL and testbench
==================================

Name: minesweeper_top

Overview:
- Top-level controller for a 5x5 (25-cell) Minesweeper game.
- Places mines pseudo-randomly, accepts cell selections, decodes each to a one-hot mask, and evaluates it (hit / clear / win).
- Tracks score and nearby-mine count, and steps a one-cycle display phase per move.
- Single clock domain; sits directly below board I/O and display logic.

Parameters:
- CELLS, 25, board size (5x5, row-major, index = row*5+col).
- SCORE_W, 32, score counter width.

Ports:
- in_clka  input  1  sole clock, rising edge (in_clkb is not used by this block).
- in_restart  input  1  reset, synchronous, active-high; also restarts the game.
- in_place  input  1  start mine placement (sampled in IDLE).
- in_data_in  input  1  user-move strobe (sampled in WAIT).
- in_data  input  5  selected cell index 0..24.
- in_mult  input  1  RNG multiplier select.
- in_increment  input  1  RNG increment select.
- in_mines_num  input  1  mine count select: 0 gives 3 mines, 1 gives 5 mines.
- out_state_main  output  4  current FSM state code.
- out_start, out_place_done, out_load, out_decode, out_alu, out_alu_done, out_display, out_display_done  output  1 each  phase flags.
- out_gameover, out_win  output  1 each  terminal flags.
- out_mines  output  25  mine bitmap.
- out_temp_data_in  output  5  latched move index.
- out_temp_decoded  output  25  one-hot move mask.
- out_temp_cleared  output  25  cleared-cell bitmap.
- out_global_score  output  32  count of safe cells cleared.
- out_n_nearby  output  2  mines among the 8 neighbours of the last move, saturating at 3.

Behaviour:
- State codes: IDLE=0, PLACE=1, WAIT=2, LOAD=3, DECODE=4, ALU=5, DISPLAY=6, GAMEOVER=7, WIN=8.
- All flags are Moore outputs decoded from the state register. Data outputs are registered.
- Reset (in_restart=1 at a clock edge) has priority over everything, including mid-game:
  - state goes to IDLE;
  - all data outputs become 0;
  - RNG state becomes 32'h0000_0001.
- RNG: 32-bit LCG advancing every clock in every state.
  - next = state*(in_mult ? 1103515245 : 69069) + (in_increment ? 12345 : 1), mod 2^32.
- IDLE:
  - out_start=1.
  - in_place=1 goes to PLACE and latches the target count (3 or 5).
- PLACE:
  - Each cycle, idx = rng[31:16] mod 25.
  - If out_mines[idx]=0, set that bit and increment the placed count; a duplicate index retries.
  - When the placed count equals the target, assert out_place_done for that cycle and go to WAIT.
- WAIT:
  - Idles until in_data_in=1.
  - On in_data_in=1, capture in_data into out_temp_data_in and go to LOAD.
- LOAD:
  - out_load=1.
  - If index > 24, go to WAIT with no other change.
  - Otherwise go to DECODE.
- DECODE:
  - out_decode=1.
  - out_temp_decoded = 1 << index, then go to ALU.
- ALU:
  - out_alu=1 and out_alu_done=1, one cycle.
  - If decoded AND mines is nonzero: go to GAMEOVER.
  - Else:
    - cleared |= decoded;
    - score +1 only if the cell was not already cleared;
    - out_n_nearby = neighbour mine count saturated to 3 (no wrap at edges or corners);
    - go to DISPLAY.
- DISPLAY:
  - out_display=1 and out_display_done=1, one cycle.
  - If cleared == ~mines (all safe cells cleared), go to WIN; else go to WAIT.
- GAMEOVER and WIN:
  - Hold their flag (out_gameover / out_win) and freeze all data until in_restart.
- Move latency: 5 clocks from the in_data_in sample to return to WAIT.

Optional Feature:
- MS_FIXED_BOARD_EN defined:
  - PLACE ignores the RNG and loads a fixed pattern in one cycle: cells {0,12,24} for 3 mines, {0,6,12,18,24} for 5 mines.
  - out_place_done asserts in that same cycle.
- Undefined: LCG placement as above.

Decomposition:
- Package ms_pkg holds:
  - state enum/codes;
  - CELLS;
  - LCG constants;
  - fixed-board masks.
- One sub-module, ms_neighbor_count: combinational, mines[24:0] plus index in, saturated 2-bit count out.

Test Plan:
- Reset then idle: in_restart=1 for one cycle, then 0 -> state 0, all data outputs 0, out_start=1.
- Placement with MS_FIXED_BOARD_EN, in_mines_num=1, in_place pulse -> out_mines=25'h1041041, out_place_done=1, state 2 next.
- Safe move: fixed 5-mine board, move 2 -> decoded=25'h4, cleared=25'h4, score=1, n_nearby=1 (neighbour 6), state 6 then 2; repeat move 2 -> score stays 1.
- Mine hit: move 12 -> out_gameover=1, state 7; in_data_in ignored until in_restart.
- Invalid index 27 -> LOAD returns to WAIT; cleared and score unchanged.
- Win: fixed 3-mine board, click all 22 safe cells -> score=22, out_win=1, state 8; without the macro, the placed mine popcount equals 3 or 5.

Source files
------------

// File: rtl/ms_pkg.sv
// Shared types, constants and RNG step for the 5x5 Minesweeper controller.
// MS_FIXED_BOARD_EN (see minesweeper_top) selects the fixed masks below instead of LCG placement.
package ms_pkg;

    localparam int CELLS = 25;
    localparam int ROWS  = 5;
    localparam int COLS  = 5;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PLACE    = 4'd1,
        ST_WAIT     = 4'd2,
        ST_LOAD     = 4'd3,
        ST_DECODE   = 4'd4,
        ST_ALU      = 4'd5,
        ST_DISPLAY  = 4'd6,
        ST_GAMEOVER = 4'd7,
        ST_WIN      = 4'd8
    } state_t;

    localparam logic [31:0] LCG_MULT_HI = 32'd1103515245;
    localparam logic [31:0] LCG_MULT_LO = 32'd69069;
    localparam logic [31:0] LCG_INC_HI  = 32'd12345;
    localparam logic [31:0] LCG_INC_LO  = 32'd1;
    localparam logic [31:0] RNG_SEED    = 32'h0000_0001;

    // Cells {0,12,24} and {0,6,12,18,24}
    localparam logic [CELLS-1:0] FIXED_MINES_3 = 25'h1001001;
    localparam logic [CELLS-1:0] FIXED_MINES_5 = 25'h1041041;

    function automatic logic [31:0] lcg_next(input logic [31:0] s,
                                             input logic        mult_sel,
                                             input logic        inc_sel);
        return s * (mult_sel ? LCG_MULT_HI : LCG_MULT_LO) + (inc_sel ? LCG_INC_HI : LCG_INC_LO);
    endfunction

endpackage

// File: rtl/ms_neighbor_count.sv
// Counts mines among the up-to-8 neighbours of a cell on the 5x5 board.
// Edges and corners do not wrap; the result saturates at 3.
module ms_neighbor_count
    import ms_pkg::*;
(
    input  logic [CELLS-1:0] mines,
    input  logic [4:0]       index,
    output logic [1:0]       count
);

    always_comb begin
        int row;
        int col;
        int r;
        int c;
        int total;
        logic [4:0] k;
        // NOTE: every variable gets a value before any conditional use, so no latch is inferred.
        row   = int'(index) / COLS;
        col   = int'(index) % COLS;
        total = 0;
        r     = 0;
        c     = 0;
        k     = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = row + dr;
                c = col + dc;
                k = 5'(r * COLS + c);
                if ((dr != 0 || dc != 0) && r >= 0 && r < ROWS && c >= 0 && c < COLS && mines[k])
                    total++;
            end
        end
        count = (total > 3) ? 2'd3 : 2'(total);
    end

endmodule

// File: rtl/minesweeper_top.sv
// Minesweeper game controller: mine placement, move decode/evaluate, score and win/lose tracking.
// Define MS_FIXED_BOARD_EN to replace LCG placement with a fixed one-cycle board.
module minesweeper_top
    import ms_pkg::*;
#(
    parameter int SCORE_W = 32
) (
    input  logic               in_clka,
    input  logic               in_restart,
    input  logic               in_place,
    input  logic               in_data_in,
    input  logic [4:0]         in_data,
    input  logic               in_mult,
    input  logic               in_increment,
    input  logic               in_mines_num,
    output logic [3:0]         out_state_main,
    output logic               out_start,
    output logic               out_place_done,
    output logic               out_load,
    output logic               out_decode,
    output logic               out_alu,
    output logic               out_alu_done,
    output logic               out_display,
    output logic               out_display_done,
    output logic               out_gameover,
    output logic               out_win,
    output logic [CELLS-1:0]   out_mines,
    output logic [4:0]         out_temp_data_in,
    output logic [CELLS-1:0]   out_temp_decoded,
    output logic [CELLS-1:0]   out_temp_cleared,
    output logic [SCORE_W-1:0] out_global_score,
    output logic [1:0]         out_n_nearby
);

    state_t      state;
    logic [31:0] rng;
    logic [2:0]  mines_target;
    logic [1:0]  nearby;

`ifndef MS_FIXED_BOARD_EN
    logic [2:0]  mines_placed;
    logic [4:0]  place_idx;

    assign place_idx = 5'(rng[31:16] % 16'd25);
`endif

    ms_neighbor_count u_neighbor_count (
        .mines (out_mines),
        .index (out_temp_data_in),
        .count (nearby)
    );

    assign out_state_main   = state;
    assign out_start        = (state == ST_IDLE);
    assign out_load         = (state == ST_LOAD);
    assign out_decode       = (state == ST_DECODE);
    assign out_alu          = (state == ST_ALU);
    assign out_alu_done     = (state == ST_ALU);
    assign out_display      = (state == ST_DISPLAY);
    assign out_display_done = (state == ST_DISPLAY);
    assign out_gameover     = (state == ST_GAMEOVER);
    assign out_win          = (state == ST_WIN);

    // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            state            <= ST_IDLE;
            rng              <= RNG_SEED;
            mines_target     <= '0;
`ifndef MS_FIXED_BOARD_EN
            mines_placed     <= '0;
`endif
            out_place_done   <= 1'b0;
            out_mines        <= '0;
            out_temp_data_in <= '0;
            out_temp_decoded <= '0;
            out_temp_cleared <= '0;
            out_global_score <= '0;
            out_n_nearby     <= '0;
        end else begin
            rng            <= lcg_next(rng, in_mult, in_increment);
            // Pulses for one cycle as the board becomes valid, i.e. in the first WAIT cycle.
            out_place_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_place) begin
                        mines_target <= in_mines_num ? 3'd5 : 3'd3;
`ifndef MS_FIXED_BOARD_EN
                        mines_placed <= '0;
`endif
                        state        <= ST_PLACE;
                    end
                end
                ST_PLACE: begin
`ifdef MS_FIXED_BOARD_EN
                    out_mines      <= (mines_target == 3'd5) ? FIXED_MINES_5 : FIXED_MINES_3;
                    out_place_done <= 1'b1;
                    state          <= ST_WAIT;
`else
                    if (!out_mines[place_idx]) begin
                        out_mines[place_idx] <= 1'b1;
                        mines_placed         <= mines_placed + 3'd1;
                        if (mines_placed + 3'd1 == mines_target) begin
                            out_place_done <= 1'b1;
                            state          <= ST_WAIT;
                        end
                    end
`endif
                end
                ST_WAIT: begin
                    if (in_data_in) begin
                        out_temp_data_in <= in_data;
                        state            <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= (out_temp_data_in > 5'(CELLS - 1)) ? ST_WAIT : ST_DECODE;
                end
                ST_DECODE: begin
                    out_temp_decoded <= CELLS'(1) << out_temp_data_in;
                    state            <= ST_ALU;
                end
                ST_ALU: begin
                    if (|(out_temp_decoded & out_mines)) begin
                        state <= ST_GAMEOVER;
                    end else begin
                        out_temp_cleared <= out_temp_cleared | out_temp_decoded;
                        if (!(|(out_temp_cleared & out_temp_decoded)))
                            out_global_score <= out_global_score + SCORE_W'(1);
                        out_n_nearby     <= nearby;
                        state            <= ST_DISPLAY;
                    end
                end
                ST_DISPLAY: begin
                    state <= (out_temp_cleared == ~out_mines) ? ST_WIN : ST_WAIT;
                end
                default: begin
                    // GAMEOVER and WIN hold until restart.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minesweeper_top.sv
// Self-checking bench for minesweeper_top: own LCG/board model and a move scoreboard.
// Works with and without MS_FIXED_BOARD_EN defined.
module tb_minesweeper_top;

    logic        in_clka = 1'b0;
    logic        in_restart, in_place, in_data_in, in_mult, in_increment, in_mines_num;
    logic [4:0]  in_data;
    logic [3:0]  out_state_main;
    logic        out_start, out_place_done, out_load, out_decode, out_alu, out_alu_done;
    logic        out_display, out_display_done, out_gameover, out_win;
    logic [24:0] out_mines, out_temp_decoded, out_temp_cleared;
    logic [4:0]  out_temp_data_in;
    logic [31:0] out_global_score;
    logic [1:0]  out_n_nearby;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  st;
        int          lat;
        logic [4:0]  tdi;
        logic [24:0] dec;
        logic [24:0] clr;
        logic [31:0] score;
        logic [1:0]  nb;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_rng;
    logic [24:0] m_mines, m_clr, m_dec;
    logic [31:0] m_score;
    logic [1:0]  m_nb;
    logic [4:0]  m_tdi;

    always #5 in_clka = ~in_clka;

    minesweeper_top dut (
        .in_clka          (in_clka),
        .in_restart       (in_restart),
        .in_place         (in_place),
        .in_data_in       (in_data_in),
        .in_data          (in_data),
        .in_mult          (in_mult),
        .in_increment     (in_increment),
        .in_mines_num     (in_mines_num),
        .out_state_main   (out_state_main),
        .out_start        (out_start),
        .out_place_done   (out_place_done),
        .out_load         (out_load),
        .out_decode       (out_decode),
        .out_alu          (out_alu),
        .out_alu_done     (out_alu_done),
        .out_display      (out_display),
        .out_display_done (out_display_done),
        .out_gameover     (out_gameover),
        .out_win          (out_win),
        .out_mines        (out_mines),
        .out_temp_data_in (out_temp_data_in),
        .out_temp_decoded (out_temp_decoded),
        .out_temp_cleared (out_temp_cleared),
        .out_global_score (out_global_score),
        .out_n_nearby     (out_n_nearby)
    );

    function automatic logic [31:0] lcg(input logic [31:0] s, input logic m, input logic i);
        return s * (m ? 32'd1103515245 : 32'd69069) + (i ? 32'd12345 : 32'd1);
    endfunction

    always @(posedge in_clka) m_rng <= in_restart ? 32'd1 : lcg(m_rng, in_mult, in_increment);

    function automatic logic [1:0] nb_count(input logic [24:0] mines, input int idx);
        int total;
        total = 0;
        for (int r = idx / 5 - 1; r <= idx / 5 + 1; r++)
            for (int c = idx % 5 - 1; c <= idx % 5 + 1; c++)
                if (r >= 0 && r < 5 && c >= 0 && c < 5 && (r * 5 + c) != idx && mines[r * 5 + c])
                    total++;
        return (total > 3) ? 2'd3 : 2'(total);
    endfunction

    task automatic do_reset();
        @(negedge in_clka);
        in_restart = 1'b1;
        in_place   = 1'b0;
        in_data_in = 1'b0;
        @(negedge in_clka);
        in_restart = 1'b0;
        m_mines = '0; m_clr = '0; m_dec = '0; m_score = '0; m_nb = '0; m_tdi = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        checks++;
        if (out_state_main !== 4'd0) begin
            failures++; $display("FAIL reset_state: got %0d want 0", out_state_main);
        end
        checks++;
        if (out_start !== 1'b1) begin
            failures++; $display("FAIL reset_start: got %b want 1", out_start);
        end
        checks++;
        if ({out_mines, out_temp_data_in, out_temp_decoded, out_temp_cleared, out_global_score,
             out_n_nearby, out_place_done, out_gameover, out_win} !== '0) begin
            failures++;
            $display("FAIL reset_data: mines=%h tdi=%0d dec=%h clr=%h score=%0d nb=%0d want all 0",
                     out_mines, out_temp_data_in, out_temp_decoded, out_temp_cleared,
                     out_global_score, out_n_nearby);
        end
    endtask

    task automatic test_place(input logic num, input logic mult, input logic inc);
        logic [31:0] r;
        logic [24:0] pm;
        logic [4:0]  idx;
        int target, placed, k, n;
        in_mult = mult; in_increment = inc; in_mines_num = num;
        target = num ? 5 : 3;
        r = m_rng;
`ifdef MS_FIXED_BOARD_EN
        pm = num ? 25'h1041041 : 25'h1001001;
        k  = 1;
        idx = '0; placed = target;
`else
        pm = '0; placed = 0; k = 0;
        r = lcg(r, mult, inc);
        while (placed < target) begin
            k++;
            idx = 5'(r[31:16] % 16'd25);
            if (!pm[idx]) begin
                pm[idx] = 1'b1;
                placed++;
            end
            r = lcg(r, mult, inc);
        end
`endif
        in_place = 1'b1;
        @(negedge in_clka);
        in_place = 1'b0;
        checks++;
        if (out_state_main !== 4'd1) begin
            failures++; $display("FAIL place_enter: state %0d want 1", out_state_main);
        end
        n = 0;
        do begin
            @(negedge in_clka);
            n++;
        end while (out_place_done !== 1'b1 && n < 600);
        checks++;
        if (n !== k) begin
            failures++; $display("FAIL place_cycles: got %0d want %0d", n, k);
        end
        checks++;
        if (out_mines !== pm) begin
            failures++; $display("FAIL place_mines: got %h want %h", out_mines, pm);
        end
        checks++;
        if ($countones(out_mines) !== target) begin
            failures++; $display("FAIL place_count: got %0d want %0d", $countones(out_mines), target);
        end
        checks++;
        if (out_state_main !== 4'd2) begin
            failures++; $display("FAIL place_state: got %0d want 2", out_state_main);
        end
        @(negedge in_clka);
        checks++;
        if (out_place_done !== 1'b0) begin
            failures++; $display("FAIL place_done_pulse: got %b want 0", out_place_done);
        end
        m_mines = pm;
    endtask

    // Predicts a move's outcome into the scoreboard, drives it, then pops and compares on completion.
    task automatic do_move(input logic [4:0] idx);
        exp_t e;
        int n;
        checks++;
        if (out_state_main !== 4'd2) begin
            failures++; $display("FAIL move_pre_state: got %0d want 2", out_state_main);
        end
        m_tdi = idx;
        if (idx > 5'd24) begin
            e.st = 4'd2; e.lat = 2;
        end else begin
            m_dec = 25'd1 << idx;
            if ((m_dec & m_mines) != 0) begin
                e.st = 4'd7; e.lat = 4;
            end else begin
                if (!m_clr[idx]) m_score++;
                m_clr = m_clr | m_dec;
                m_nb  = nb_count(m_mines, int'(idx));
                e.st  = (m_clr == ~m_mines) ? 4'd8 : 4'd2;
                e.lat = 5;
            end
        end
        e.tdi = m_tdi; e.dec = m_dec; e.clr = m_clr; e.score = m_score; e.nb = m_nb;
        sb.push_back(e);
        in_data    = idx;
        in_data_in = 1'b1;
        n = 0;
        do begin
            @(negedge in_clka);
            n++;
            if (n == 1) begin
                in_data_in = 1'b0;
                checks++;
                if (out_load !== 1'b1) begin
                    failures++; $display("FAIL move_load_flag: got %b want 1", out_load);
                end
            end
        end while (!(out_state_main inside {4'd2, 4'd7, 4'd8}) && n < 20);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat) begin
            failures++; $display("FAIL move_latency idx=%0d: got %0d want %0d", idx, n, e.lat);
        end
        checks++;
        if (out_state_main !== e.st) begin
            failures++; $display("FAIL move_state idx=%0d: got %0d want %0d", idx, out_state_main, e.st);
        end
        checks++;
        if (out_temp_data_in !== e.tdi || out_temp_decoded !== e.dec || out_temp_cleared !== e.clr) begin
            failures++;
            $display("FAIL move_data idx=%0d: tdi=%0d dec=%h clr=%h want tdi=%0d dec=%h clr=%h",
                     idx, out_temp_data_in, out_temp_decoded, out_temp_cleared, e.tdi, e.dec, e.clr);
        end
        checks++;
        if (out_global_score !== e.score || out_n_nearby !== e.nb) begin
            failures++;
            $display("FAIL move_score idx=%0d: score=%0d nb=%0d want score=%0d nb=%0d",
                     idx, out_global_score, out_n_nearby, e.score, e.nb);
        end
        checks++;
        if (out_gameover !== (e.st == 4'd7) || out_win !== (e.st == 4'd8)) begin
            failures++;
            $display("FAIL move_terminal idx=%0d: gameover=%b win=%b want state %0d",
                     idx, out_gameover, out_win, e.st);
        end
    endtask

    function automatic int first_safe(input logic [24:0] mines, input int skip);
        for (int i = 0; i < 25; i++)
            if (!mines[i] && i != skip) return i;
        return 0;
    endfunction

    task automatic test_safe_move();
        int c, c2;
        c  = m_mines[2] ? first_safe(m_mines, -1) : 2;
        do_move(5'(c));
        do_move(5'(c));
        c2 = first_safe(m_mines, c);
        do_move(5'(c2));
    endtask

    task automatic test_invalid();
        do_move(5'd27);
        do_move(5'd31);
    endtask

    // Sends a move to a frozen terminal state and checks nothing moves.
    task automatic check_frozen(input logic [3:0] st);
        logic [31:0] score_before;
        logic [4:0]  tdi_before;
        score_before = out_global_score;
        tdi_before   = out_temp_data_in;
        in_data      = 5'(first_safe(m_mines, int'(tdi_before)));
        in_data_in   = 1'b1;
        repeat (3) @(negedge in_clka);
        in_data_in = 1'b0;
        repeat (5) @(negedge in_clka);
        checks++;
        if (out_state_main !== st || out_global_score !== m_score || out_temp_data_in !== m_tdi) begin
            failures++;
            $display("FAIL frozen: state=%0d score=%0d tdi=%0d want state=%0d score=%0d tdi=%0d",
                     out_state_main, out_global_score, out_temp_data_in, st, m_score, m_tdi);
        end
    endtask

    task automatic test_mine_hit();
        int m;
        m = 0;
        for (int i = 24; i >= 0; i--) if (m_mines[i]) m = i;
        do_move(5'(m));
        check_frozen(4'd7);
    endtask

    task automatic test_win();
        for (int i = 0; i < 25; i++)
            if (!m_mines[i]) do_move(5'(i));
        checks++;
        if (out_win !== 1'b1 || out_global_score !== 32'd22) begin
            failures++; $display("FAIL win_final: win=%b score=%0d want win=1 score=22",
                                 out_win, out_global_score);
        end
        check_frozen(4'd8);
    endtask

    initial begin
        in_restart = 1'b1; in_place = 1'b0; in_data_in = 1'b0; in_data = '0;
        in_mult = 1'b0; in_increment = 1'b0; in_mines_num = 1'b0;
        do_reset();
        test_reset();
        test_place(1'b1, 1'b0, 1'b0);
        test_safe_move();
        test_invalid();
        test_mine_hit();
        do_reset();
        test_reset();
        test_place(1'b0, 1'b1, 1'b1);
        test_win();
        do_reset();
        test_reset();
        test_place(1'b1, 1'b1, 1'b0);
        test_safe_move();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule
